// File: rtl/pipe_stage_regs.sv
// D/E/M/W pipeline register bank with stall-driven E bubbles.
// Optional stall/retire counters built when PIPE_PERF_CNT_EN is defined.
module pipe_stage_regs #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      f_I,
  input  logic [31:0]      f_PC,
  input  logic             f_valid,
  input  logic             Stall,
  output logic             pc_en,
  output logic [31:0]      d_I,
  output logic [31:0]      ex_I,
  output logic [31:0]      mem_I,
  output logic [31:0]      wb_I,
  output logic [31:0]      d_PC,
  output logic [31:0]      ex_PC,
  output logic [31:0]      mem_PC,
  output logic [31:0]      wb_PC,
  output logic             d_valid,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef struct packed {
    logic [31:0] i;
    logic [31:0] pc;
    logic        v;
  } stg_t;

  localparam stg_t BUBBLE = '{i: NOP_WORD, pc: 32'h0, v: 1'b0};

  stg_t d_q, e_q, m_q, w_q;

  assign pc_en = ~Stall;

  // D holds and E takes a bubble on stall; M and W never stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_q <= BUBBLE;
      e_q <= BUBBLE;
      m_q <= BUBBLE;
      w_q <= BUBBLE;
    end else begin
      if (!Stall)
        d_q <= '{i: f_I, pc: f_PC, v: f_valid};
      e_q <= Stall ? BUBBLE : d_q;
      m_q <= e_q;
      w_q <= m_q;
    end
  end

  assign d_I       = d_q.i;
  assign ex_I      = e_q.i;
  assign mem_I     = m_q.i;
  assign wb_I      = w_q.i;
  assign d_PC      = d_q.pc;
  assign ex_PC     = e_q.pc;
  assign mem_PC    = m_q.pc;
  assign wb_PC     = w_q.pc;
  assign d_valid   = d_q.v;
  assign ex_valid  = e_q.v;
  assign mem_valid = m_q.v;
  assign wb_valid  = w_q.v;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] retire_q;

  // Saturating counters; cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q  <= '0;
      retire_q <= '0;
    end else begin
      if (Stall && !(&stall_q))
        stall_q <= stall_q + CNT_W'(1);
      if (w_q.v && !(&retire_q))
        retire_q <= retire_q + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_q;
  assign retire_cnt = retire_q;
`else
  assign stall_cnt  = '0;
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Bench for pipe_stage_regs: directed scenario tasks plus a
// retirement scoreboard checking every instruction leaving W.
module tb_pipe_stage_regs;

  localparam int CNT_W = 4;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic [31:0]      f_I;
  logic [31:0]      f_PC;
  logic             f_valid;
  logic             Stall;
  logic             pc_en;
  logic [31:0]      d_I, ex_I, mem_I, wb_I;
  logic [31:0]      d_PC, ex_PC, mem_PC, wb_PC;
  logic             d_valid, ex_valid, mem_valid, wb_valid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] retire_cnt;

  int passed = 0;
  int total  = 0;

  logic [63:0] sb[$];

  localparam logic [31:0] LW   = 32'h8C22_0000;
  localparam logic [31:0] ADDU = 32'h0022_1821;
  localparam logic [31:0] JUNK = 32'h3C0F_FFFF;

  pipe_stage_regs #(
    .NOP_WORD(32'h0000_0000),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .f_I       (f_I),
    .f_PC      (f_PC),
    .f_valid   (f_valid),
    .Stall     (Stall),
    .pc_en     (pc_en),
    .d_I       (d_I),
    .ex_I      (ex_I),
    .mem_I     (mem_I),
    .wb_I      (wb_I),
    .d_PC      (d_PC),
    .ex_PC     (ex_PC),
    .mem_PC    (mem_PC),
    .wb_PC     (wb_PC),
    .d_valid   (d_valid),
    .ex_valid  (ex_valid),
    .mem_valid (mem_valid),
    .wb_valid  (wb_valid),
    .stall_cnt (stall_cnt),
    .retire_cnt(retire_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Instruction accepted into D: expect it to leave W later, in order.
  always @(posedge clk)
    if (reset && !Stall && f_valid)
      sb.push_back({f_I, f_PC});

  always @(negedge reset) sb.delete();

  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
    end else if (wb_valid) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_retire: got %h/%h required nothing", wb_I, wb_PC);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        if ({wb_I, wb_PC} !== e)
          $display("FAIL sb_retire: got %h/%h required %h/%h",
                   wb_I, wb_PC, e[63:32], e[31:0]);
        else
          passed++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] i, input logic [31:0] pc);
    f_I = i;
    f_PC = pc;
    f_valid = 1'b1;
    tick();
  endtask

  task automatic flush(input int n);
    f_I = '0;
    f_PC = '0;
    f_valid = 1'b0;
    Stall = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    Stall = 1'b0;
    f_I = 32'h3C01_1234;
    f_PC = 32'h0000_0100;
    f_valid = 1'b1;
    repeat (3) tick();
    total++;
    if ({d_I, ex_I, mem_I, wb_I} !== '0)
      $display("FAIL reset_I: got %h required 0", {d_I, ex_I, mem_I, wb_I});
    else passed++;
    total++;
    if ({d_PC, ex_PC, mem_PC, wb_PC} !== '0)
      $display("FAIL reset_PC: got %h required 0",
               {d_PC, ex_PC, mem_PC, wb_PC});
    else passed++;
    total++;
    if ({d_valid, ex_valid, mem_valid, wb_valid} !== 4'b0)
      $display("FAIL reset_valid: got %b required 0000",
               {d_valid, ex_valid, mem_valid, wb_valid});
    else passed++;
    total++;
    if ({stall_cnt, retire_cnt} !== '0)
      $display("FAIL reset_cnt: got %h required 0", {stall_cnt, retire_cnt});
    else passed++;
    reset = 1'b1;
    tick();
    total++;
    if (d_I !== 32'h3C01_1234 || d_valid !== 1'b1)
      $display("FAIL reset_release_d: got %h/%b required 3c011234/1",
               d_I, d_valid);
    else passed++;
    f_I = '0;
    f_PC = '0;
    f_valid = 1'b0;
    repeat (3) tick();
    total++;
    if (wb_I !== 32'h3C01_1234 || wb_valid !== 1'b1)
      $display("FAIL reset_release_wb: got %h/%b required 3c011234/1",
               wb_I, wb_valid);
    else passed++;
    flush(2);
  endtask

  task automatic test_straight_line();
    for (int k = 0; k < 3; k++) begin
      f_I = 32'h2401_0000 + 32'(k);
      f_PC = 32'h3000 + 32'(4 * k);
      f_valid = 1'b1;
      #1;
      total++;
      if (pc_en !== 1'b1)
        $display("FAIL straight_pc_en: got %b required 1", pc_en);
      else passed++;
      tick();
    end
    total++;
    if ({d_PC, ex_PC, mem_PC} !== {32'h3008, 32'h3004, 32'h3000})
      $display("FAIL straight_pcs: got %h/%h/%h required 3008/3004/3000",
               d_PC, ex_PC, mem_PC);
    else passed++;
    flush(4);
  endtask

  task automatic test_load_use();
    feed(LW, 32'h4000);
    feed(ADDU, 32'h4004);
    f_I = JUNK;
    f_PC = 32'h4008;
    f_valid = 1'b1;
    Stall = 1'b1;
    #1;
    total++;
    if (pc_en !== 1'b0)
      $display("FAIL lu_pc_en: got %b required 0", pc_en);
    else passed++;
    tick();
    total++;
    if (d_I !== ADDU || ex_I !== 32'h0 || ex_valid !== 1'b0 || mem_I !== LW)
      $display("FAIL lu_stall: got d=%h ex=%h/%b mem=%h required %h/0/0/%h",
               d_I, ex_I, ex_valid, mem_I, ADDU, LW);
    else passed++;
    Stall = 1'b0;
    tick();
    total++;
    if (ex_I !== ADDU || ex_valid !== 1'b1 || d_I !== JUNK)
      $display("FAIL lu_resume: got ex=%h/%b d=%h required %h/1/%h",
               ex_I, ex_valid, d_I, ADDU, JUNK);
    else passed++;
    flush(5);
  endtask

  task automatic test_double_stall();
    feed(32'h2402_0001, 32'h5000);
    feed(32'h2403_0002, 32'h5004);
    f_I = JUNK;
    f_valid = 1'b1;
    Stall = 1'b1;
    tick();
    total++;
    if (d_I !== 32'h2403_0002 || ex_valid !== 1'b0 ||
        mem_I !== 32'h2402_0001)
      $display("FAIL ds_edge1: got d=%h exv=%b mem=%h", d_I, ex_valid, mem_I);
    else passed++;
    tick();
    total++;
    if (d_I !== 32'h2403_0002 || d_PC !== 32'h5004 ||
        {ex_valid, mem_valid} !== 2'b00 || wb_I !== 32'h2402_0001)
      $display("FAIL ds_edge2: got d=%h/%h v=%b%b wb=%h",
               d_I, d_PC, ex_valid, mem_valid, wb_I);
    else passed++;
    Stall = 1'b0;
    f_valid = 1'b0;
    tick();
    total++;
    if (ex_I !== 32'h2403_0002 || {mem_valid, wb_valid} !== 2'b00)
      $display("FAIL ds_edge3: got ex=%h v=%b%b required 24030002/00",
               ex_I, mem_valid, wb_valid);
    else passed++;
    tick();
    total++;
    if (mem_I !== 32'h2403_0002 || wb_valid !== 1'b0)
      $display("FAIL ds_edge4: got mem=%h wbv=%b", mem_I, wb_valid);
    else passed++;
    tick();
    total++;
    if (wb_I !== 32'h2403_0002 || wb_valid !== 1'b1)
      $display("FAIL ds_edge5: got wb=%h/%b", wb_I, wb_valid);
    else passed++;
    flush(3);
  endtask

  task automatic test_reset_mid_stall();
    feed(32'h2404_0004, 32'h6000);
    feed(32'h2405_0005, 32'h6004);
    Stall = 1'b1;
    tick();
    #1;
    reset = 1'b0;
    #1;
    total++;
    if ({d_I, ex_I, mem_I, wb_I, d_PC, ex_PC, mem_PC, wb_PC} !== '0 ||
        {d_valid, ex_valid, mem_valid, wb_valid} !== 4'b0 ||
        {stall_cnt, retire_cnt} !== '0)
      $display("FAIL mid_stall_reset: got d=%h/%h/%b required 0",
               d_I, d_PC, d_valid);
    else passed++;
    Stall = 1'b0;
    f_valid = 1'b0;
    tick();
    reset = 1'b1;
    flush(2);
  endtask

  task automatic test_counters();
    logic [CNT_W-1:0] exp5, exp_sat;
    exp5 = PERF ? CNT_W'(5) : '0;
    exp_sat = PERF ? '1 : '0;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    f_valid = 1'b0;
    Stall = 1'b1;
    repeat (5) tick();
    total++;
    if (stall_cnt !== exp5)
      $display("FAIL cnt_stall5: got %0d required %0d", stall_cnt, exp5);
    else passed++;
    repeat (15) tick();
    total++;
    if (stall_cnt !== exp_sat)
      $display("FAIL cnt_stall_sat: got %0d required %0d", stall_cnt, exp_sat);
    else passed++;
    Stall = 1'b0;
    for (int k = 0; k < 20; k++)
      feed(32'h2406_0000 + 32'(k), 32'h7000 + 32'(4 * k));
    flush(4);
    total++;
    if (retire_cnt !== exp_sat || stall_cnt !== exp_sat)
      $display("FAIL cnt_retire_sat: got %0d/%0d required %0d/%0d",
               retire_cnt, stall_cnt, exp_sat, exp_sat);
    else passed++;
  endtask

  initial begin
    reset = 1'b0;
    Stall = 1'b0;
    f_I = '0;
    f_PC = '0;
    f_valid = 1'b0;
    test_reset();
    test_straight_line();
    test_load_use();
    test_double_stall();
    test_reset_mid_stall();
    test_counters();
    total++;
    if (sb.size() != 0)
      $display("FAIL sb_drain: got %0d pending required 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
